writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Collects completed results from the functional units and turns them into register-file writebacks. Each cycle it picks one result using round-robin arbitration and registers it. On the next cycle it drives the one-hot write strobe and the broadcast data into the per-register cells. It sits between the execute stage and the register file, and it also produces a forwarding tag for the issue stage. It checks every writeback against the register's write-reservation bit and flags writes to registers that were never reserved.

## Interface
Parameters:
- LEN_REG, from defs_insn.v: register data width.
- N_REG, default 16: number of architectural registers.
- LOG_N_REG, default 4: register index width, equal to clog2(N_REG).
- N_SRC, default 4: number of result sources (functional units), at least 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- src_valid_i  input  N_SRC  bit k high means source k holds a result.
- src_ready_o  output  N_SRC  bit k high means source k's result is taken this cycle.
- src_rd_i  input  N_SRC*LOG_N_REG  destination index; source k occupies slice [k*LOG_N_REG +: LOG_N_REG].
- src_data_i  input  N_SRC*LEN_REG  result data; source k occupies slice [k*LEN_REG +: LEN_REG].
- reserved_i  input  N_REG  per-register write-reservation bits from the register cells.
- wb_o  output  N_REG  one-hot write strobe, one bit per register cell.
- data_o  output  LEN_REG  writeback data, broadcast to all cells.
- byp_valid_o  output  1  a writeback is occurring this cycle (forwarding valid).
- byp_rd_o  output  LOG_N_REG  destination index of the current writeback.
- err_o  output  1  sticky flag: a write targeted an unreserved register.

## Operation
- Round-robin pointer `ptr` (LOG2(N_SRC) bits, reset 0) names the highest-priority source.
- Grant selection is combinational:
  - Grant goes to the first k with src_valid_i[k] set, scanning k = ptr, ptr+1, … modulo N_SRC.
  - src_ready_o is one-hot for the granted source, or all zeros when no source is valid.
- Pointer update on a grant to source g: ptr <= (g+1) mod N_SRC. With no grant, ptr holds.
- Output register, loaded every cycle:
  - Grant present: out_valid <= 1, out_rd <= src_rd_i slice of g, out_data <= src_data_i slice of g.
  - No grant: out_valid <= 0. out_rd and out_data hold their previous values.
- Output decode:
  - wb_o = out_valid ? (1 << out_rd) : 0.
  - data_o = out_data.
  - byp_valid_o = out_valid.
  - byp_rd_o = out_rd.
- Reservation check: if a grant's destination rd has reserved_i[rd] == 0 in the grant cycle, err_o <= 1. err_o is cleared only by reset.
- Backpressure: the register cells always accept a writeback, so the output never stalls. Throughput is one writeback per cycle.
- Indices out of range (rd >= N_REG): wb_o is all zeros, err_o is set, and byp_valid_o still asserts.

## Timing
- Reset values:
  - wb_o = 0, data_o = 0, byp_valid_o = 0, byp_rd_o = 0, err_o = 0, ptr = 0.
  - src_ready_o = 0 while rst is low.
- Transfer: src_valid_i[k] and src_ready_o[k] both high at clock edge t.
- Latency: wb_o[rd] and data_o are valid during cycle t+1 for exactly one cycle. The register cell captures them at edge t+1.
- Two sources targeting the same rd in one cycle: only one is granted, and the other waits at least one cycle. Order follows ptr.
- A source may hold its valid high across cycles. Its data must stay stable until its ready is seen.
- A source cannot be starved: worst-case wait is N_SRC-1 cycles while the others stay continuously valid.
- Reset asserted mid-operation: any pending output is dropped immediately (asynchronously) and no strobe is emitted.

## Structure
- LEN_REG and the register index width come from the shared defs_insn.v. Add N_SRC and LOG_N_SRC to the same file.
- One natural sub-module, `rr_arbiter`: parameter N, inputs req[N], clk, rst, and advance; outputs grant[N], one-hot, and owns the pointer.
- The register cells are instantiated by the register-file wrapper, not by this block.

## Test plan
- After reset release with no valid sources: wb_o=0, byp_valid_o=0 and err_o=0 for 10 cycles; ptr stays 0.
- Single write: src 2 presents rd=5 with data 0xA5 and reserved_i[5]=1. Required: src_ready_o=4'b0100 at t, then wb_o=16'h0020 and data_o=0xA5 at t+1 only.
- Round robin: all 4 sources continuously valid with distinct rd. Grants follow 0,1,2,3,0,…, with one wb_o pulse per cycle.
- Same-rd conflict: src 1 and src 3 both target rd=7 with ptr=2. Src 3 goes first (wb at t+1), then src 1 (wb at t+2), and data_o matches each in turn.
- Unreserved write: rd=9 with reserved_i[9]=0. err_o rises at t+1 and stays high through later legal writes until reset.
- Reset mid-flight: a grant at edge t, then rst pulled low during cycle t+1. wb_o drops to 0 immediately, and after release no strobe occurs for that result.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback-path definitions: default register/data widths, source count
// and the modulo increment used by the round-robin pointer.
package writeback_arbiter_pkg;

    localparam int WB_LEN_REG   = 32;
    localparam int WB_N_REG     = 16;
    localparam int WB_LOG_N_REG = 4;
    localparam int WB_N_SRC     = 4;
    localparam int WB_LOG_N_SRC = 2;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr;
// ptr moves to one past the winner whenever a grant is taken.
module rr_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int LOG_N = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    logic [LOG_N-1:0] ptr;
    logic [LOG_N-1:0] ptr_next;
    logic [N-1:0]     grant_raw;
    logic             found;

    always_comb begin
        grant_raw = '0;
        ptr_next  = ptr;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant_raw[idx] = 1'b1;
                ptr_next       = LOG_N'(rr_next(idx, N));
                found          = 1'b1;
            end
        end
    end

    // Nothing may be taken from a source while the block is held in reset.
    assign grant = rst ? grant_raw : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Picks one completed functional-unit result per cycle, registers it and drives
// the one-hot register-file write strobe, broadcast data and forwarding tag.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int LEN_REG   = WB_LEN_REG,
    parameter int N_REG     = WB_N_REG,
    parameter int LOG_N_REG = WB_LOG_N_REG,
    parameter int N_SRC     = WB_N_SRC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           src_valid_i,
    output logic [N_SRC-1:0]           src_ready_o,
    input  logic [N_SRC*LOG_N_REG-1:0] src_rd_i,
    input  logic [N_SRC*LEN_REG-1:0]   src_data_i,
    input  logic [N_REG-1:0]           reserved_i,
    output logic [N_REG-1:0]           wb_o,
    output logic [LEN_REG-1:0]         data_o,
    output logic                       byp_valid_o,
    output logic [LOG_N_REG-1:0]       byp_rd_o,
    output logic                       err_o
);

    logic [N_SRC-1:0]     grant;
    logic                 grant_any;
    logic [LOG_N_REG-1:0] g_rd;
    logic [LEN_REG-1:0]   g_data;
    logic                 g_bad;

    logic                 out_valid;
    logic [LOG_N_REG-1:0] out_rd;
    logic [LEN_REG-1:0]   out_data;
    logic                 err;

    // The register cells never refuse a write, so the arbiter always advances.
    rr_arbiter #(
        .N (N_SRC)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (src_valid_i),
        .advance (1'b1),
        .grant   (grant)
    );

    assign src_ready_o = grant;
    assign grant_any   = |grant;

    always_comb begin
        g_rd   = '0;
        g_data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            g_rd   = g_rd   | (src_rd_i[k*LOG_N_REG +: LOG_N_REG] & {LOG_N_REG{grant[k]}});
            g_data = g_data | (src_data_i[k*LEN_REG +: LEN_REG]   & {LEN_REG{grant[k]}});
        end
    end

    // Out-of-range destinations count as unreserved.
    always_comb begin
        g_bad = 1'b1;
        if (int'(g_rd) < N_REG) begin
            g_bad = !reserved_i[g_rd];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            out_valid <= grant_any;
            if (grant_any) begin
                out_rd   <= g_rd;
                out_data <= g_data;
                if (g_bad) begin
                    err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        wb_o = '0;
        if (out_valid && (int'(out_rd) < N_REG)) begin
            wb_o[out_rd] = 1'b1;
        end
    end

    assign data_o      = out_data;
    assign byp_valid_o = out_valid;
    assign byp_rd_o    = out_rd;
    assign err_o       = err;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed, table-driven bench for writeback_arbiter with hand-computed
// expectations plus reset and mid-flight reset sequences.
module tb_writeback_arbiter;

    localparam int LEN_REG   = 32;
    localparam int N_REG     = 16;
    localparam int LOG_N_REG = 4;
    localparam int N_SRC     = 4;

    logic                       clk;
    logic                       rst;
    logic [N_SRC-1:0]           src_valid_i;
    logic [N_SRC-1:0]           src_ready_o;
    logic [N_SRC*LOG_N_REG-1:0] src_rd_i;
    logic [N_SRC*LEN_REG-1:0]   src_data_i;
    logic [N_REG-1:0]           reserved_i;
    logic [N_REG-1:0]           wb_o;
    logic [LEN_REG-1:0]         data_o;
    logic                       byp_valid_o;
    logic [LOG_N_REG-1:0]       byp_rd_o;
    logic                       err_o;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_arbiter #(
        .LEN_REG   (LEN_REG),
        .N_REG     (N_REG),
        .LOG_N_REG (LOG_N_REG),
        .N_SRC     (N_SRC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_rd_i    (src_rd_i),
        .src_data_i  (src_data_i),
        .reserved_i  (reserved_i),
        .wb_o        (wb_o),
        .data_o      (data_o),
        .byp_valid_o (byp_valid_o),
        .byp_rd_o    (byp_rd_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   valid;
        logic [15:0]  rd;
        logic [127:0] data;
        logic [15:0]  rsv;
        logic [3:0]   exp_ready;
        logic [15:0]  exp_wb;
        logic [31:0]  exp_data;
        logic         exp_bv;
        logic [3:0]   exp_rd;
        logic         exp_err;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic [3:0] valid, input logic [15:0] rd,
                                input logic [127:0] data, input logic [15:0] rsv,
                                input logic [3:0] er, input logic [15:0] ewb,
                                input logic [31:0] ed, input logic ebv,
                                input logic [3:0] erd, input logic eerr);
        vec_t v;
        v.valid = valid; v.rd = rd; v.data = data; v.rsv = rsv;
        v.exp_ready = er; v.exp_wb = ewb; v.exp_data = ed; v.exp_bv = ebv;
        v.exp_rd = erd; v.exp_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        // ptr: 0 -> V0 grants 2 -> 3; V2 grants 3 -> 0; RR 0,1,2,3,0 -> 1;
        // V8 grants 1 -> 2; V9 grants 3; V10 grants 1; V11 grants 0; V12 grants 1.
        vecs[0]  = mk(4'b0100, {4'd0,4'd5,4'd0,4'd0}, {32'h0,32'hA5,32'h0,32'h0}, 16'hFFFF,
                      4'b0100, 16'h0020, 32'hA5, 1'b1, 4'd5, 1'b0);
        vecs[1]  = mk(4'b0000, 16'h0, 128'h0, 16'hFFFF,
                      4'b0000, 16'h0000, 32'hA5, 1'b0, 4'd5, 1'b0);
        vecs[2]  = mk(4'b1000, {4'd4,4'd0,4'd0,4'd0}, {32'h33,32'h0,32'h0,32'h0}, 16'hFFFF,
                      4'b1000, 16'h0010, 32'h33, 1'b1, 4'd4, 1'b0);
        vecs[3]  = mk(4'b1111, {4'd4,4'd3,4'd2,4'd1}, {32'h13,32'h12,32'h11,32'h10}, 16'hFFFF,
                      4'b0001, 16'h0002, 32'h10, 1'b1, 4'd1, 1'b0);
        vecs[4]  = mk(4'b1111, {4'd4,4'd3,4'd2,4'd1}, {32'h13,32'h12,32'h11,32'h10}, 16'hFFFF,
                      4'b0010, 16'h0004, 32'h11, 1'b1, 4'd2, 1'b0);
        vecs[5]  = mk(4'b1111, {4'd4,4'd3,4'd2,4'd1}, {32'h13,32'h12,32'h11,32'h10}, 16'hFFFF,
                      4'b0100, 16'h0008, 32'h12, 1'b1, 4'd3, 1'b0);
        vecs[6]  = mk(4'b1111, {4'd4,4'd3,4'd2,4'd1}, {32'h13,32'h12,32'h11,32'h10}, 16'hFFFF,
                      4'b1000, 16'h0010, 32'h13, 1'b1, 4'd4, 1'b0);
        vecs[7]  = mk(4'b1111, {4'd4,4'd3,4'd2,4'd1}, {32'h13,32'h12,32'h11,32'h10}, 16'hFFFF,
                      4'b0001, 16'h0002, 32'h10, 1'b1, 4'd1, 1'b0);
        vecs[8]  = mk(4'b0010, {4'd0,4'd0,4'd6,4'd0}, {32'h0,32'h0,32'h66,32'h0}, 16'hFFFF,
                      4'b0010, 16'h0040, 32'h66, 1'b1, 4'd6, 1'b0);
        vecs[9]  = mk(4'b1010, {4'd7,4'd0,4'd7,4'd0}, {32'h73,32'h0,32'h71,32'h0}, 16'hFFFF,
                      4'b1000, 16'h0080, 32'h73, 1'b1, 4'd7, 1'b0);
        vecs[10] = mk(4'b0010, {4'd7,4'd0,4'd7,4'd0}, {32'h73,32'h0,32'h71,32'h0}, 16'hFFFF,
                      4'b0010, 16'h0080, 32'h71, 1'b1, 4'd7, 1'b0);
        vecs[11] = mk(4'b0001, {4'd0,4'd0,4'd0,4'd9}, {32'h0,32'h0,32'h0,32'h99}, 16'hFDFF,
                      4'b0001, 16'h0200, 32'h99, 1'b1, 4'd9, 1'b1);
        vecs[12] = mk(4'b0010, {4'd0,4'd0,4'd3,4'd0}, {32'h0,32'h0,32'h31,32'h0}, 16'hFFFF,
                      4'b0010, 16'h0008, 32'h31, 1'b1, 4'd3, 1'b1);
        vecs[13] = mk(4'b0000, 16'h0, 128'h0, 16'hFFFF,
                      4'b0000, 16'h0000, 32'h31, 1'b0, 4'd3, 1'b1);

        rst         = 1'b0;
        src_valid_i = 4'b1111;
        src_rd_i    = '0;
        src_data_i  = '0;
        reserved_i  = 16'hFFFF;
        #12;
        chk("reset_ready", src_ready_o, 4'b0000);
        chk("reset_wb", wb_o, 16'h0);
        chk("reset_data", data_o, 32'h0);
        chk("reset_byp_valid", byp_valid_o, 1'b0);
        chk("reset_byp_rd", byp_rd_o, 4'd0);
        chk("reset_err", err_o, 1'b0);
        src_valid_i = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("idle_wb", wb_o, 16'h0);
            chk("idle_byp_valid", byp_valid_o, 1'b0);
            chk("idle_err", err_o, 1'b0);
        end

        for (int i = 0; i < 14; i++) begin
            src_valid_i = vecs[i].valid;
            src_rd_i    = vecs[i].rd;
            src_data_i  = vecs[i].data;
            reserved_i  = vecs[i].rsv;
            #1;
            chk($sformatf("v%0d_ready", i), src_ready_o, vecs[i].exp_ready);
            @(posedge clk); #1;
            chk($sformatf("v%0d_wb", i), wb_o, vecs[i].exp_wb);
            chk($sformatf("v%0d_data", i), data_o, vecs[i].exp_data);
            chk($sformatf("v%0d_byp_valid", i), byp_valid_o, vecs[i].exp_bv);
            chk($sformatf("v%0d_byp_rd", i), byp_rd_o, vecs[i].exp_rd);
            chk($sformatf("v%0d_err", i), err_o, vecs[i].exp_err);
        end

        // Mid-flight reset: grant at edge t, reset during cycle t+1.
        src_valid_i = 4'b0001;
        src_rd_i    = {4'd0, 4'd0, 4'd0, 4'd2};
        src_data_i  = {32'h0, 32'h0, 32'h0, 32'h55};
        reserved_i  = 16'hFFFF;
        #1;
        chk("mf_ready", src_ready_o, 4'b0001);
        @(posedge clk); #1;
        chk("mf_wb_before", wb_o, 16'h0004);
        #2;
        rst = 1'b0;
        #1;
        chk("mf_wb_dropped", wb_o, 16'h0);
        chk("mf_byp_dropped", byp_valid_o, 1'b0);
        chk("mf_err_cleared", err_o, 1'b0);
        chk("mf_ready_in_reset", src_ready_o, 4'b0000);
        src_valid_i = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("mf_no_strobe", wb_o, 16'h0);
            chk("mf_no_byp", byp_valid_o, 1'b0);
        end

        // Pointer must restart at source 0 after reset.
        src_valid_i = 4'b1111;
        src_rd_i    = {4'd12, 4'd11, 4'd10, 4'd8};
        src_data_i  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        #1;
        chk("post_rst_ready", src_ready_o, 4'b0001);
        @(posedge clk); #1;
        chk("post_rst_wb", wb_o, 16'h0100);
        chk("post_rst_data", data_o, 32'hD0);
        chk("post_rst_ready2", src_ready_o, 4'b0010);
        src_valid_i = 4'b0000;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
